// File: rtl/imm_pkg.sv
// imm_pkg: loader state type and reset-default immediates shared by immediate_table
package imm_pkg;
  typedef enum logic {IDLE, LOAD} imm_state_e;
  localparam int IMM_NDEF = 6;
  localparam logic [7:0] IMM_DEF [IMM_NDEF] = '{8'd0, 8'd1, 8'd29, 8'd128, 8'd59, 8'd4};
  function automatic logic [7:0] imm_default(int i);
    imm_default = 8'd0;
    for (int k = 0; k < IMM_NDEF; k++) if (i == k) imm_default = IMM_DEF[k];
  endfunction
endpackage

// File: rtl/imm_loader.sv
// imm_loader: bulk-load FSM; streams load beats into consecutive table entries
module imm_loader
  import imm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic                       valid_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       ready_o,
  output logic                       done_o,
  output logic                       we_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o,
  output logic [WIDTH-1:0]           data_o
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
  imm_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic done_q, done_d;
  logic hs, last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  assign hs   = (state_q == LOAD) && valid_i;
  assign last = ptr_q == LAST;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      state_d = start_i ? LOAD : IDLE;
      ptr_d   = start_i ? '0 : ptr_q;
    end else if (hs) begin
      state_d = last ? IDLE : LOAD;
      ptr_d   = last ? '0 : ptr_q + 1'b1;
      done_d  = last;
    end
  end
  assign ready_o = state_q == LOAD;
  assign done_o  = done_q;
  assign we_o    = hs;
  assign idx_o   = ptr_q;
  assign data_o  = data_i;
endmodule

// File: rtl/immediate_table.sv
// immediate_table: register-file immediate table with write-first reads and bulk reload.
// Optional IMM_TABLE_PARITY_EN adds per-entry even parity, rd_perr and inject_perr.
module immediate_table
  import imm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rd_req,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     rd_err,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [WIDTH-1:0]         load_data,
  output logic                     load_ready,
  output logic                     load_done
`ifdef IMM_TABLE_PARITY_EN
  ,
  input  logic                     inject_perr,
  output logic                     rd_perr
`endif
);
  localparam int IW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic loading, ld_we, we, rd_ok, byp;
  logic [IW-1:0] ld_idx, w_idx;
  logic [WIDTH-1:0] ld_data, w_data, rd_word;
  logic [WIDTH-1:0] rd_data_q;
  logic rd_valid_q, rd_err_q;
  imm_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_loader (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (load_start),
    .valid_i (load_valid),
    .data_i  (load_data),
    .ready_o (loading),
    .done_o  (load_done),
    .we_o    (ld_we),
    .idx_o   (ld_idx),
    .data_o  (ld_data)
  );
  // The loader owns the write port for the whole LOAD state
  assign we      = loading ? ld_we : wr_en && (int'(wr_idx) < DEPTH);
  assign w_idx   = loading ? ld_idx : wr_idx;
  assign w_data  = loading ? ld_data : wr_data;
  assign rd_ok   = int'(rd_idx) < DEPTH;
  assign byp     = we && (w_idx == rd_idx);
  assign rd_word = byp ? w_data : mem_q[rd_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= WIDTH'(imm_default(e));
    end else if (we) begin
      mem_q[w_idx] <= w_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      rd_err_q   <= rd_req && !rd_ok;
      if (rd_req) rd_data_q <= rd_ok ? rd_word : '0;
    end
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign load_ready = loading;
`ifdef IMM_TABLE_PARITY_EN
  logic par_q [DEPTH];
  logic w_par, rd_par, rd_perr_q;
  assign w_par  = (^w_data) ^ inject_perr;
  assign rd_par = byp ? w_par : par_q[rd_idx];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) par_q[e] <= ^(WIDTH'(imm_default(e)));
      rd_perr_q <= 1'b0;
    end else begin
      if (we) par_q[w_idx] <= w_par;
      rd_perr_q <= rd_req && rd_ok && ((^rd_word) != rd_par);
    end
  assign rd_perr = rd_perr_q;
`endif
endmodule

// File: tb/tb_immediate_table.sv
// tb_immediate_table: random + directed checks of immediate_table against a behavioural model
module tb_immediate_table;
  localparam int D  = 8;
  localparam int D6 = 6;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       rd_req = 1'b0, wr_en = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic [2:0] rd_idx = '0, wr_idx = '0;
  logic [7:0] wr_data = '0, load_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_err, load_ready, load_done;
  logic       r6_req = 1'b0, w6_en = 1'b0;
  logic [2:0] r6_idx = '0, w6_idx = '0;
  logic [7:0] w6_data = '0;
  logic [7:0] r6_data;
  logic       r6_valid, r6_err, l6_ready, l6_done;
`ifdef IMM_TABLE_PARITY_EN
  logic inject_perr = 1'b0;
  logic rd_perr, r6_perr;
  bit   pb [D];
  bit   e_perr;
`endif
  immediate_table #(.WIDTH(8), .DEPTH(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_idx(rd_idx), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_err(rd_err), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done)
`ifdef IMM_TABLE_PARITY_EN
    , .inject_perr(inject_perr), .rd_perr(rd_perr)
`endif
  );
  immediate_table #(.WIDTH(8), .DEPTH(D6)) u_d6 (
    .clk(clk), .rst_n(rst_n), .rd_req(r6_req), .rd_idx(r6_idx), .rd_data(r6_data),
    .rd_valid(r6_valid), .rd_err(r6_err), .wr_en(w6_en), .wr_idx(w6_idx), .wr_data(w6_data),
    .load_start(1'b0), .load_valid(1'b0), .load_data(8'h00),
    .load_ready(l6_ready), .load_done(l6_done)
`ifdef IMM_TABLE_PARITY_EN
    , .inject_perr(1'b0), .rd_perr(r6_perr)
`endif
  );
  logic [7:0] DEF [6] = '{8'd0, 8'd1, 8'd29, 8'd128, 8'd59, 8'd4};
  logic [7:0] m [D];
  logic [7:0] m6 [D6];
  bit m_load;
  int m_ptr;
  bit e_valid, e_err, e_done, e6_valid, e6_err;
  logic [7:0] e_data, e6_data;
  int n_chk = 0, n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_req = 0; wr_en = 0; load_start = 0; load_valid = 0;
    r6_req = 0; w6_en = 0;
`ifdef IMM_TABLE_PARITY_EN
    inject_perr = 0;
`endif
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i] = (i < 6) ? DEF[i] : 8'd0;
    for (int i = 0; i < D6; i++) m6[i] = DEF[i];
`ifdef IMM_TABLE_PARITY_EN
    for (int i = 0; i < D; i++) pb[i] = 0;
`endif
    m_load = 0;
    m_ptr = 0;
  endtask

  // Called at posedge+1; pulses reset asynchronously between clock edges
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_valid", rd_valid, 0);
    chk("rst_err", rd_err, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_done", load_done, 0);
    chk("rst_valid6", r6_valid, 0);
    idle();
    #2 rst_n = 1;
  endtask

  task automatic tick();
    bit w, was_load, w6;
    int wi, wi6;
    logic [7:0] wd;
    w = 0; wi = 0; wd = 0;
    was_load = m_load;
    if (was_load) begin
      if (load_valid) begin w = 1; wi = m_ptr; wd = load_data; end
    end else if (wr_en && int'(wr_idx) < D) begin
      w = 1; wi = int'(wr_idx); wd = wr_data;
    end
    e_valid = rd_req;
    e_err = rd_req && int'(rd_idx) >= D;
    if (rd_req) e_data = e_err ? 8'd0 : (w && wi == int'(rd_idx)) ? wd : m[rd_idx];
`ifdef IMM_TABLE_PARITY_EN
    e_perr = rd_req && !e_err && ((w && wi == int'(rd_idx)) ? inject_perr : pb[rd_idx]);
    if (w) pb[wi] = inject_perr;
`endif
    if (w) m[wi] = wd;
    e_done = was_load && load_valid && m_ptr == D - 1;
    if (was_load && load_valid) m_ptr = (m_ptr + 1) % D;
    if (e_done) m_load = 0;
    else if (!was_load && load_start) begin m_load = 1; m_ptr = 0; end
    w6 = w6_en && int'(w6_idx) < D6;
    wi6 = int'(w6_idx);
    e6_valid = r6_req;
    e6_err = r6_req && int'(r6_idx) >= D6;
    if (r6_req) e6_data = e6_err ? 8'd0 : (w6 && wi6 == int'(r6_idx)) ? w6_data : m6[r6_idx];
    if (w6) m6[wi6] = w6_data;
    @(posedge clk);
    #1;
    chk("rd_valid", rd_valid, e_valid);
    if (e_valid) begin
      chk("rd_data", rd_data, e_data);
      chk("rd_err", rd_err, e_err);
`ifdef IMM_TABLE_PARITY_EN
      chk("rd_perr", rd_perr, e_perr);
`endif
    end
    chk("load_ready", load_ready, m_load);
    chk("load_done", load_done, e_done);
    chk("rd_valid6", r6_valid, e6_valid);
    if (e6_valid) begin
      chk("rd_data6", r6_data, e6_data);
      chk("rd_err6", r6_err, e6_err);
    end
    chk("load_ready6", l6_ready, 0);
    chk("load_done6", l6_done, 0);
  endtask

  task automatic read_chk(int i, logic [7:0] exp);
    rd_req = 1;
    rd_idx = 3'(i);
    tick();
    rd_req = 0;
    chk($sformatf("entry%0d", i), rd_data, exp);
  endtask

  initial begin
    int beat, cyc, ndone;
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < D; i++) read_chk(i, (i < 6) ? DEF[i] : 8'd0);
    // write-first bypass
    wr_en = 1; wr_idx = 3; wr_data = 8'h55; rd_req = 1; rd_idx = 3;
    tick();
    idle();
    chk("bypass", rd_data, 8'h55);
    // out of range on the DEPTH=6 instance
    r6_req = 1; r6_idx = 7;
    tick();
    chk("oor_valid", r6_valid, 1);
    chk("oor_err", r6_err, 1);
    chk("oor_data", r6_data, 0);
    r6_req = 0; w6_en = 1; w6_idx = 7; w6_data = 8'hEE;
    tick();
    w6_idx = 6;
    tick();
    w6_en = 0;
    for (int i = 0; i < D6; i++) begin
      r6_req = 1; r6_idx = 3'(i);
      tick();
      chk($sformatf("oor_keep%0d", i), r6_data, DEF[i]);
    end
    r6_req = 0;
    // bulk load with gaps and ignored single writes
    load_start = 1;
    tick();
    load_start = 0;
    beat = 0; cyc = 0; ndone = 0;
    while (beat < D && cyc < 100) begin
      load_valid = (cyc % 3 == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      load_data = 8'h10 + 8'(beat);
      wr_en = 1; wr_idx = 3'(beat); wr_data = 8'hAA;
      load_start = 1'($urandom_range(0, 1));
      rd_req = 1'($urandom_range(0, 1)); rd_idx = 3'($urandom);
      tick();
      if (load_valid) beat++;
      if (load_done) ndone++;
      cyc++;
    end
    chk("load_beats", beat, D);
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (load_done) ndone++;
    end
    chk("load_done_cnt", ndone, 1);
    chk("load_idle", load_ready, 0);
    for (int i = 0; i < D; i++) read_chk(i, 8'h10 + 8'(i));
    // reset in the middle of a load
    load_start = 1;
    tick();
    load_start = 0;
    load_valid = 1;
    for (int i = 0; i < 3; i++) begin
      load_data = 8'h40 + 8'(i);
      tick();
    end
    do_reset();
    load_valid = 1; load_data = 8'h99;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load_done) ndone++;
    end
    idle();
    chk("midrst_done", ndone, 0);
    chk("midrst_ready", load_ready, 0);
    for (int i = 0; i < D; i++) read_chk(i, (i < 6) ? DEF[i] : 8'd0);
`ifdef IMM_TABLE_PARITY_EN
    wr_en = 1; wr_idx = 2; wr_data = 8'h3C; inject_perr = 1;
    tick();
    idle();
    rd_req = 1; rd_idx = 2;
    tick();
    chk("perr_inj", rd_perr, 1);
    rd_idx = 1;
    tick();
    chk("perr_clean", rd_perr, 0);
    idle();
`endif
    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rd_req = 1'($urandom_range(0, 1)); rd_idx = 3'($urandom);
      wr_en = 1'($urandom_range(0, 1)); wr_idx = 3'($urandom); wr_data = 8'($urandom);
      load_start = ($urandom_range(0, 39) == 0);
      load_valid = 1'($urandom_range(0, 1)); load_data = 8'($urandom);
      r6_req = 1'($urandom_range(0, 1)); r6_idx = 3'($urandom);
      w6_en = 1'($urandom_range(0, 1)); w6_idx = 3'($urandom); w6_data = 8'($urandom);
`ifdef IMM_TABLE_PARITY_EN
      inject_perr = ($urandom_range(0, 7) == 0);
`endif
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end
    idle();
    tick();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/immediate_table.md
IMMEDIATE_TABLE -- requirements
Module: immediate_table

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the immediate data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning the number of entries (2..256, not necessarily a power of two); IW = clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 SHALL have port rd_req, input, 1 bit, the read request.
REQ-006 SHALL have port rd_idx, input, IW bits, the read index.
REQ-007 SHALL have port rd_data, output, WIDTH bits, the registered immediate.
REQ-008 SHALL have port rd_valid, output, 1 bit, high one cycle after an accepted rd_req.
REQ-009 SHALL have port rd_err, output, 1 bit, qualified by rd_valid, flagging an out-of-range index.
REQ-010 SHALL have ports wr_en (input, 1), wr_idx (input, IW) and wr_data (input, WIDTH), the single-entry write port.
REQ-011 SHALL have port load_start, input, 1 bit, which begins a bulk reload.
REQ-012 SHALL have ports load_valid (input, 1), load_data (input, WIDTH) and load_ready (output, 1), the bulk-load stream handshake.
REQ-013 SHALL have port load_done, output, 1 bit, a one-cycle pulse at the end of a bulk load.

Function
REQ-014 SHALL reset entries 0..5 to 0, 1, 29, 128, 59, 4 (truncated to WIDTH) and all remaining entries to 0.
REQ-015 SHALL register rd_data, rd_valid and rd_err one cycle after rd_req, giving a read latency of exactly 1 cycle; rd_valid SHALL stay low when rd_req is low.
REQ-016 SHALL, when rd_idx >= DEPTH, return rd_data = 0 and rd_err = 1 with rd_valid = 1.
REQ-017 SHALL, on a same-cycle read and write to the same index, return the newly written data (write-first bypass).
REQ-018 SHALL update the entry at the clock edge when wr_en = 1 and wr_idx < DEPTH, and SHALL ignore wr_en when wr_idx >= DEPTH.
REQ-019 SHALL implement a bulk-load FSM with two states: IDLE (load_ready = 0) and LOAD (load_ready = 1).
REQ-020 SHALL go IDLE -> LOAD on load_start and clear the load pointer to 0; load_start while in LOAD SHALL be ignored.
REQ-021 SHALL, in LOAD, write load_data to entry[ptr] and increment ptr on each cycle with load_valid && load_ready.
REQ-022 SHALL, on the handshake at ptr = DEPTH-1, return to IDLE and pulse load_done in the following cycle; ptr SHALL wrap to 0.
REQ-023 SHALL ignore wr_en while in LOAD (the bulk load has priority).
REQ-024 SHALL let reads proceed during LOAD, with the bypass of REQ-017 applying to load writes.

Reset
REQ-025 SHALL, on rst_n low and at any time including mid-load, immediately restore the defaults of REQ-014, force the FSM to IDLE with ptr = 0, and drive rd_valid, rd_err, rd_data, load_ready and load_done to 0.
REQ-026 SHALL NOT resume an interrupted bulk load after reset release.

Configuration
REQ-027 SHALL, with IMM_TABLE_PARITY_EN defined, store an even-parity bit per entry on every write and reset, and add output rd_perr (1 bit, qualified by rd_valid) flagging a parity mismatch on the read entry.
REQ-028 SHALL provide a test-only input inject_perr that flips the stored parity bit of the entry being written; it exists only with IMM_TABLE_PARITY_EN defined.
REQ-029 SHALL, without IMM_TABLE_PARITY_EN, have no parity storage, no rd_perr port and no inject_perr port.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, LOAD) and the default-value constant array in a shared package, imm_pkg.
REQ-031 SHALL implement the bulk-load FSM and pointer as a sub-module, imm_loader, which issues write strobes into the table storage.

Verification
REQ-032 SHALL verify reset defaults: release reset, read indices 0..7 -> 0, 1, 29, 128, 59, 4, 0, 0, each with rd_valid one cycle later.
REQ-033 SHALL verify write-first bypass: wr_en with idx 3 and data 0x55 plus rd_req with idx 3 in the same cycle -> rd_data = 0x55 next cycle.
REQ-034 SHALL verify out of range: DEPTH = 6, rd_idx = 7 -> rd_valid = 1, rd_err = 1, rd_data = 0; wr_en at idx 7 leaves all entries unchanged.
REQ-035 SHALL verify bulk load: load_start, then 8 beats 0x10..0x17 with gaps in load_valid -> entries hold 0x10..0x17, load_done pulses once, FSM returns to IDLE; wr_en during the load is ignored.
REQ-036 SHALL verify mid-load reset: assert rst_n low after 3 beats -> defaults restored, load_ready = 0, no load_done.
REQ-037 SHALL verify parity (IMM_TABLE_PARITY_EN): write idx 2 with inject_perr = 1, then read idx 2 -> rd_perr = 1; read idx 1 -> rd_perr = 0.
